// File: rtl/afe_reg_ctrl.sv
// Register-access sequencer for the AFE: frames a 4-byte SPI transaction
// (address + 24-bit payload) on top of an external byte engine.
module afe_reg_ctrl #(
  parameter int TIMEOUT = 31
) (
  input  logic        div_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rw,
  input  logic [7:0]  addr,
  input  logic [23:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [23:0] rdata,
  output logic        spi_wr_en,
  output logic        spi_rd_en,
  output logic [7:0]  spi_tx_data,
  output logic        spi_flag,
  output logic        spi_stage_rst,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx_data
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, XFER, GAP, FINISH, ERR} state_t;

  state_t        state;
  logic [1:0]    byte_idx;
  logic [TW-1:0] tmo_cnt;
  logic          rw_q;
  logic [23:0]   wdata_q;
  logic [15:0]   shadow;

  // Byte placed on the wire for a given slot; read payload slots clock out zeros.
  function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic is_rd,
                                         input logic [7:0] a, input logic [23:0] d);
    logic [7:0] b;
    case (idx)
      2'd0:    b = a;
      2'd1:    b = is_rd ? 8'h00 : d[23:16];
      2'd2:    b = is_rd ? 8'h00 : d[15:8];
      default: b = is_rd ? 8'h00 : d[7:0];
    endcase
    return b;
  endfunction

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      byte_idx      <= '0;
      tmo_cnt       <= '0;
      rw_q          <= 1'b0;
      wdata_q       <= '0;
      shadow        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      spi_wr_en     <= 1'b0;
      spi_rd_en     <= 1'b0;
      spi_tx_data   <= '0;
      spi_flag      <= 1'b0;
      spi_stage_rst <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done          <= 1'b0;
          err           <= 1'b0;
          spi_rd_en     <= 1'b0;
          spi_flag      <= 1'b0;
          spi_stage_rst <= 1'b0;
          if (start) begin
            rw_q        <= rw;
            wdata_q     <= wdata;
            byte_idx    <= '0;
            tmo_cnt     <= '0;
            busy        <= 1'b1;
            spi_wr_en   <= 1'b1;
            spi_tx_data <= tx_byte(2'd0, rw, addr, wdata);
            state       <= XFER;
          end else begin
            spi_wr_en   <= 1'b0;
            spi_tx_data <= '0;
          end
        end

        XFER: begin
          if (spi_done) begin
            if (rw_q && byte_idx == 2'd1) shadow[15:8] <= spi_rx_data;
            if (rw_q && byte_idx == 2'd2) shadow[7:0]  <= spi_rx_data;
            spi_wr_en <= 1'b0;
            spi_rd_en <= 1'b0;
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              spi_flag <= 1'b1;
              state    <= GAP;
            end else begin
              // Final byte goes straight into rdata so it is valid alongside done.
              if (rw_q) rdata <= {shadow, spi_rx_data};
              spi_stage_rst <= 1'b1;
              done          <= 1'b1;
              err           <= 1'b0;
              state         <= FINISH;
            end
          end else if (tmo_cnt == TMO_MAX) begin
            spi_wr_en     <= 1'b0;
            spi_rd_en     <= 1'b0;
            spi_stage_rst <= 1'b1;
            done          <= 1'b1;
            err           <= 1'b1;
            state         <= ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        GAP: begin
          spi_flag    <= 1'b0;
          tmo_cnt     <= '0;
          spi_wr_en   <= (byte_idx == 2'd0) || !rw_q;
          spi_rd_en   <= (byte_idx != 2'd0) && rw_q;
          spi_tx_data <= tx_byte(byte_idx, rw_q, 8'h00, wdata_q);
          state       <= XFER;
        end

        FINISH, ERR: begin
          busy          <= 1'b0;
          done          <= 1'b0;
          err           <= 1'b0;
          spi_stage_rst <= 1'b0;
          spi_tx_data   <= '0;
          byte_idx      <= '0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afe_reg_ctrl.sv
// Bench for afe_reg_ctrl: behavioural SPI byte engine, directed vector table,
// reset/overlap sequences and randomized transactions against a transaction-level model.
module tb_afe_reg_ctrl;

  localparam int TMO = 31;

  logic        div_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [7:0]  addr = '0;
  logic [23:0] wdata = '0;
  logic        busy, done, err;
  logic [23:0] rdata;
  logic        spi_wr_en, spi_rd_en;
  logic [7:0]  spi_tx_data;
  logic        spi_flag, spi_stage_rst;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_rx_data = '0;

  afe_reg_ctrl #(.TIMEOUT(TMO)) dut (
    .div_clk(div_clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .spi_wr_en(spi_wr_en), .spi_rd_en(spi_rd_en), .spi_tx_data(spi_tx_data),
    .spi_flag(spi_flag), .spi_stage_rst(spi_stage_rst),
    .spi_done(spi_done), .spi_rx_data(spi_rx_data)
  );

  always #5 div_clk = ~div_clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Engine / observation state
  int         lat [4];
  logic [7:0] rxb [4];
  logic [7:0] wire_b [4];
  logic       wire_rd [4];
  int  eng_nb, eng_cnt;
  bit  eng_busy, in_txn;
  int  cyc_n, flag_cnt, stg_cnt, done_cnt, both_cnt, gap_cnt, done_at, a_n;
  logic        err_at;
  logic [23:0] rdata_at;

  typedef struct packed {
    logic        r;
    logic [7:0]  a;
    logic [23:0] d;
    int          l0, l1, l2, l3;
    logic [31:0] rx;
    logic [31:0] exp_bytes;
    int          exp_nb;
    logic        exp_err;
    logic [23:0] exp_rdata;
    int          exp_lat;
    int          exp_flg;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // One clock: observe this cycle's outputs at negedge, then drive the engine's inputs.
  task automatic cyc();
    @(negedge div_clk);
    cyc_n++;
    if (spi_flag) flag_cnt++;
    if (spi_stage_rst) stg_cnt++;
    if (spi_wr_en && spi_rd_en) both_cnt++;
    if (in_txn && !(spi_wr_en || spi_rd_en || spi_flag || spi_stage_rst)) gap_cnt++;
    if (spi_wr_en || spi_rd_en) in_txn = 1;
    if (done) begin
      done_cnt++; done_at = cyc_n; err_at = err; rdata_at = rdata; in_txn = 0;
    end
    spi_done = 1'b0;
    if (!rst_n || spi_stage_rst) eng_busy = 0;
    else if (eng_busy) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        spi_done = 1'b1; spi_rx_data = rxb[eng_nb-1]; eng_busy = 0;
      end
    end else if ((spi_wr_en || spi_rd_en) && eng_nb < 4) begin
      wire_b[eng_nb] = spi_tx_data; wire_rd[eng_nb] = spi_rd_en;
      eng_cnt = lat[eng_nb]; eng_nb++; eng_busy = 1;
    end
  endtask

  task automatic clear_obs();
    flag_cnt = 0; stg_cnt = 0; done_cnt = 0; both_cnt = 0; gap_cnt = 0;
    eng_nb = 0; eng_busy = 0; in_txn = 0; done_at = 0;
    for (int i = 0; i < 4; i++) begin wire_b[i] = '0; wire_rd[i] = 1'b0; end
  endtask

  task automatic run_txn(input logic r, input logic [7:0] a, input logic [23:0] d, input bit poke);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin cyc(); guard++; end
    clear_obs();
    rw = r; addr = a; wdata = d; start = 1'b1; a_n = cyc_n;
    cyc();
    start = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 400) begin
      if (poke && cyc_n == a_n + 3) begin start = 1'b1; rw = ~r; addr = ~a; wdata = ~d; end
      else start = 1'b0;
      cyc(); guard++;
    end
    start = 1'b0;
    if (poke) begin
      start = 1'b1;          // lands in the FINISH/ERR cycle
      cyc();
      start = 1'b0;
      cyc(); cyc();
      check("poke_busy_after", {31'b0, busy}, 32'd0);
      check("poke_done_count", done_cnt, 32'd1);
    end
  endtask

  // Transaction-level model: which byte (if any) exceeds the timeout decides everything.
  task automatic check_txn(input logic r, input logic [7:0] a, input logic [23:0] d,
                           inout logic [23:0] prev);
    int jf, nb, expl, flg;
    bit e;
    logic [23:0] er;
    logic [7:0]  eb;
    jf = 4;
    for (int i = 0; i < 4; i++) if (jf == 4 && lat[i] > TMO) jf = i;
    e    = (jf < 4);
    nb   = e ? jf + 1 : 4;
    flg  = e ? jf : 3;
    expl = 1;
    for (int i = 0; i < jf; i++) expl += lat[i] + 1;
    expl += e ? (jf + TMO + 1) : 3;
    er = (r && !e) ? {rxb[1], rxb[2], rxb[3]} : prev;
    check("m_done_count", done_cnt, 32'd1);
    check("m_err", {31'b0, err_at}, {31'b0, e});
    check("m_latency", done_at - a_n, expl);
    check("m_flag_cycles", flag_cnt, flg);
    check("m_stage_rst", stg_cnt, 32'd1);
    check("m_nbytes", eng_nb, nb);
    check("m_en_overlap", both_cnt, 32'd0);
    check("m_cs_gap", gap_cnt, 32'd0);
    check("m_rdata", {8'h0, rdata_at}, {8'h0, er});
    for (int i = 0; i < nb; i++) begin
      eb = (i == 0) ? a : (r ? 8'h00 : 8'(d >> (8 * (3 - i))));
      check("m_wire_byte", {24'h0, wire_b[i]}, {24'h0, eb});
      check("m_rd_en", {31'b0, wire_rd[i]}, {31'b0, (i > 0) && r});
    end
    prev = er;
  endtask

  initial begin
    logic [23:0] prev;
    logic        r;
    logic [7:0]  a;
    logic [23:0] d;
    int          guard;
    logic [31:0] act_bytes;

    //           r     a      d            l0    l1 l2 l3  rx            bytes         nb err rdata       lat flg
    tbl[0] = '{1'b0, 8'h01, 24'hA5C3F0,  2,    2, 2, 2, 32'hDEADBEEF, 32'h01A5C3F0, 4, 1'b0, 24'h000000, 16, 3};
    tbl[1] = '{1'b1, 8'h2A, 24'h777777,  1,    3, 2, 4, 32'h00123456, 32'h2A000000, 4, 1'b0, 24'h123456, 18, 3};
    tbl[2] = '{1'b1, 8'h10, 24'h000000,  1,    1, 1, 1, 32'h99111111, 32'h10000000, 4, 1'b0, 24'h111111, 12, 3};
    tbl[3] = '{1'b1, 8'h20, 24'h000000,  1,    1, 1, 1, 32'h99222222, 32'h20000000, 4, 1'b0, 24'h222222, 12, 3};
    tbl[4] = '{1'b0, 8'h33, 24'h445566,  1000, 1, 1, 1, 32'h00000000, 32'h33000000, 1, 1'b1, 24'h222222, 33, 0};
    tbl[5] = '{1'b1, 8'h44, 24'h000000,  31,   1, 1, 1, 32'h00ABCDEF, 32'h44000000, 4, 1'b0, 24'hABCDEF, 42, 3};
    tbl[6] = '{1'b1, 8'h55, 24'h000000,  1,    1, 32, 1, 32'h00998877, 32'h55000000, 3, 1'b1, 24'hABCDEF, 39, 2};
    tbl[7] = '{1'b0, 8'h00, 24'h000001,  1,    1, 1, 1, 32'h00000000, 32'h00000001, 4, 1'b0, 24'hABCDEF, 12, 3};

    cyc_n = 0;
    clear_obs();
    for (int i = 0; i < 4; i++) begin lat[i] = 1; rxb[i] = '0; end
    repeat (3) cyc();
    check("reset_ctrl", {25'b0, busy, done, err, spi_wr_en, spi_rd_en, spi_flag, spi_stage_rst}, 32'd0);
    check("reset_tx", {24'h0, spi_tx_data}, 32'd0);
    check("reset_rdata", {8'h0, rdata}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Directed table, issued back to back
    for (int v = 0; v < 8; v++) begin
      lat[0] = tbl[v].l0; lat[1] = tbl[v].l1; lat[2] = tbl[v].l2; lat[3] = tbl[v].l3;
      for (int i = 0; i < 4; i++) rxb[i] = 8'(tbl[v].rx >> (8 * (3 - i)));
      run_txn(tbl[v].r, tbl[v].a, tbl[v].d, 1'b0);
      act_bytes = {wire_b[0], wire_b[1], wire_b[2], wire_b[3]};
      check("t_done_count", done_cnt, 32'd1);
      check("t_bytes", act_bytes, tbl[v].exp_bytes);
      check("t_nbytes", eng_nb, tbl[v].exp_nb);
      check("t_err", {31'b0, err_at}, {31'b0, tbl[v].exp_err});
      check("t_rdata", {8'h0, rdata_at}, {8'h0, tbl[v].exp_rdata});
      check("t_latency", done_at - a_n, tbl[v].exp_lat);
      check("t_flag_cycles", flag_cnt, tbl[v].exp_flg);
      check("t_stage_rst", stg_cnt, 32'd1);
      check("t_cs_gap", gap_cnt, 32'd0);
    end
    prev = tbl[7].exp_rdata;

    // start pulsed mid-write and in the FINISH cycle must be ignored
    for (int i = 0; i < 4; i++) begin lat[i] = 2; rxb[i] = 8'h5A; end
    run_txn(1'b0, 8'h5A, 24'h0F1E2D, 1'b1);
    check_txn(1'b0, 8'h5A, 24'h0F1E2D, prev);

    // Reset asserted during byte 2 of a read
    lat[0] = 2; lat[1] = 2; lat[2] = 6; lat[3] = 2;
    for (int i = 0; i < 4; i++) rxb[i] = 8'hC0 + 8'(i);
    guard = 0;
    while (busy && guard < 100) begin cyc(); guard++; end
    clear_obs();
    rw = 1'b1; addr = 8'h66; start = 1'b1;
    cyc();
    start = 1'b0;
    guard = 0;
    while (eng_nb < 3 && guard < 100) begin cyc(); guard++; end
    cyc();
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {25'b0, busy, done, err, spi_wr_en, spi_rd_en, spi_flag, spi_stage_rst}, 32'd0);
    check("rst_mid_tx", {24'h0, spi_tx_data}, 32'd0);
    check("rst_mid_rdata", {8'h0, rdata}, 32'd0);
    cyc(); cyc();
    check("rst_mid_no_done", done_cnt, 32'd0);
    rst_n = 1'b1;
    cyc();
    prev = '0;
    for (int i = 0; i < 4; i++) lat[i] = 1;
    run_txn(1'b0, 8'h00, 24'h000001, 1'b0);
    check_txn(1'b0, 8'h00, 24'h000001, prev);

    // Randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      r = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      d = 24'($urandom);
      for (int i = 0; i < 4; i++) begin
        lat[i] = $urandom_range(1, 5);
        rxb[i] = 8'($urandom);
      end
      case ($urandom_range(0, 9))
        0: lat[$urandom_range(0, 3)] = TMO + 1 + $urandom_range(0, 2);
        1: lat[$urandom_range(0, 3)] = TMO;
        default: ;
      endcase
      run_txn(r, a, d, $urandom_range(0, 7) == 0);
      check_txn(r, a, d, prev);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
